mmcm_lock_sequencer: RTL
========================

// Module: mmcm_lock_sequencer
// PURPOSE
//  Power-up/reset sequencer for the MMCME2_BASE clock divider. Runs off the free-running board
//  clock `clk`, not the MMCM output. Drives the MMCM RST/PWRDWN pins and watches LOCKED.
//  Releases a clean clk_ready to downstream logic only after the lock has been stable.
//  Retries a failed lock a bounded number of times, then reports a fault.
// PARAMETERS
//  RST_CYCLES    16      cycles mmcm_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT  100000  max cycles in WAIT_LOCK before the attempt fails (1 ms at 100 MHz)
//  LOCK_STABLE   64      consecutive synced-locked cycles required before clk_ready
//  MAX_RETRIES   3       extra reset attempts after the first one fails
// PORTS
//  clk          in   1  free-running input clock (same net as the MMCM CLKIN1)
//  rst          in   1  async active-high reset
//  enable       in   1  1 = bring the MMCM up and keep it up; 0 = power it down
//  mmcm_locked  in   1  MMCM LOCKED, asynchronous to clk
//  mmcm_rst     out  1  to MMCM RST
//  mmcm_pwrdwn  out  1  to MMCM PWRDWN
//  clk_ready    out  1  MMCM output clock is valid; use it for downstream reset release
//  lol_pulse    out  1  one-cycle pulse on loss of lock while in RUN
//  fault        out  1  retries exhausted; sticky until enable=0
//  retry_cnt    out  W  attempts failed so far; W=$clog2(MAX_RETRIES+1)
//  lol_count    out  8  loss-of-lock event count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: mmcm_rst=1, mmcm_pwrdwn=1, clk_ready=0, lol_pulse=0, fault=0,
//    retry_cnt=0, lol_count=0, state=OFF.
//  - mmcm_locked passes through a 2-FF synchronizer to give locked_s (2-cycle latency).
//  - All outputs are registered. An output changes the cycle after the state transition that causes it.
//  - FSM states:
//   OFF: pwrdwn=1, rst=1, ready=0, retry_cnt=0.
//        enable=1 -> RESET.
//   RESET: pwrdwn=0, rst=1 for exactly RST_CYCLES cycles.
//        Then -> WAIT_LOCK, with the timeout counter cleared.
//   WAIT_LOCK: rst=0, timeout counter increments.
//        locked_s=1 -> STABLE.
//        Counter reaches LOCK_TIMEOUT-1 -> attempt fails:
//          if retry_cnt<MAX_RETRIES: retry_cnt++ and go to RESET;
//          else go to FAULT.
//   STABLE: counts consecutive locked_s=1 cycles; the timeout counter keeps running.
//        locked_s=0 -> back to WAIT_LOCK; the stable count clears, the timeout counter does not.
//        Count reaches LOCK_STABLE -> RUN.
//        Timeout reached in STABLE is treated the same as a timeout in WAIT_LOCK.
//   RUN: ready=1, retry_cnt=0.
//        locked_s=0 -> ready=0 next cycle, lol_pulse=1 for one cycle, then go to RESET.
//        retry_cnt stays at 0 on this path, so a fresh retry budget applies.
//   FAULT: pwrdwn=0, rst=1, ready=0, fault=1.
//        Only enable=0 leaves this state -> OFF, with fault cleared.
//  - enable=0 in any state -> OFF next cycle. This takes priority over every other transition.
//  - A glitch on locked_s in RUN always triggers a full re-lock; there is no filtering in RUN.
//  - Counters never wrap. The timeout and stable counters are sized $clog2(param+1).
//  - Async rst mid-operation: all state returns to the reset values immediately. clk_ready drops
//    asynchronously.
// CONFIGURATION
//  MMCM_SEQ_LOL_COUNT_EN defined:
//   - lol_count increments on every lol_pulse and saturates at 255.
//   - It is cleared only by rst.
//  Not defined: lol_count is tied to 8'd0 and no counter logic is generated.
//  The port list is identical in both builds.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2)
//  1. Nominal bring-up: rst released, enable=1, locked rises 10 cycles after mmcm_rst falls
//     -> mmcm_rst high exactly 4 cycles; clk_ready rises 2+8+1 cycles after locked.
//  2. Locked never rises -> three attempts (retry_cnt 0,1,2); fault=1 at about cycle 3*(4+20);
//     mmcm_rst stays 1. Then enable=0 -> fault=0, mmcm_pwrdwn=1.
//  3. Locked drops for 1 cycle during STABLE (count=5) -> count restarts. clk_ready occurs only
//     after 8 unbroken cycles, or a timeout at 20 if those 8 cycles do not complete in time.
//  4. In RUN, locked drops for 3 cycles -> lol_pulse single cycle, clk_ready=0, mmcm_rst pulses 4
//     cycles, re-lock to RUN. With the macro: lol_count=1; without it: lol_count=0.
//  5. enable=0 during RESET and during RUN -> OFF next cycle, mmcm_pwrdwn=1, clk_ready=0;
//     re-enable restarts from RESET.
//  6. Async rst asserted mid-WAIT_LOCK between clock edges -> outputs reach their reset values
//     without waiting for a clk edge.

Source files
------------

// File: rtl/mmcm_lock_sequencer.sv
// ============================================================================
//  Module      : mmcm_lock_sequencer
//  Description : Power-up / re-lock sequencer for an MMCME2_BASE, clocked from
//                the free-running board clock. Optional loss-of-lock counter
//                is built when MMCM_SEQ_LOL_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmcm_lock_sequencer #(
    parameter int  RST_CYCLES   = 16,
    parameter int  LOCK_TIMEOUT = 100000,
    parameter int  LOCK_STABLE  = 64,
    parameter int  MAX_RETRIES  = 3,
    localparam int c_retry_w    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mmcm_locked,
    output logic                 mmcm_rst,
    output logic                 mmcm_pwrdwn,
    output logic                 clk_ready,
    output logic                 lol_pulse,
    output logic                 fault,
    output logic [c_retry_w-1:0] retry_cnt,
    output logic [7:0]           lol_count
);

    localparam int c_rst_w = $clog2(RST_CYCLES + 1);
    localparam int c_tmo_w = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_stb_w = $clog2(LOCK_STABLE + 1);

    localparam logic [c_rst_w-1:0]   c_rst_last  = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last  = c_tmo_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_stb_w-1:0]   c_stb_last  = c_stb_w'(LOCK_STABLE - 1);
    localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    logic [c_rst_w-1:0]   r_rst_cnt;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [c_stb_w-1:0]   r_stable;

    // LOCKED comes straight from the MMCM and is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_OFF;
            mmcm_rst    <= 1'b1;
            mmcm_pwrdwn <= 1'b1;
            clk_ready   <= 1'b0;
            lol_pulse   <= 1'b0;
            fault       <= 1'b0;
            retry_cnt   <= '0;
            r_rst_cnt   <= '0;
            r_tmo       <= '0;
            r_stable    <= '0;
        end else begin
            lol_pulse <= 1'b0;
            if (!enable) begin
                r_state     <= ST_OFF;
                mmcm_rst    <= 1'b1;
                mmcm_pwrdwn <= 1'b1;
                clk_ready   <= 1'b0;
                fault       <= 1'b0;
                retry_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state     <= ST_RESET;
                        mmcm_pwrdwn <= 1'b0;
                        mmcm_rst    <= 1'b1;
                        r_rst_cnt   <= '0;
                    end
                    ST_RESET: begin
                        if (r_rst_cnt == c_rst_last) begin
                            r_state  <= ST_WAIT_LOCK;
                            mmcm_rst <= 1'b0;
                            r_tmo    <= '0;
                            r_stable <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + c_rst_w'(1);
                        end
                    end
                    // The timeout spans the whole attempt, so it has priority
                    // over lock qualification in both states.
                    ST_WAIT_LOCK, ST_STABLE: begin
                        if (r_tmo == c_tmo_last) begin
                            mmcm_rst  <= 1'b1;
                            r_rst_cnt <= '0;
                            if (retry_cnt < c_max_retry) begin
                                retry_cnt <= retry_cnt + c_retry_w'(1);
                                r_state   <= ST_RESET;
                            end else begin
                                r_state <= ST_FAULT;
                                fault   <= 1'b1;
                            end
                        end else begin
                            r_tmo <= r_tmo + c_tmo_w'(1);
                            if (!r_lock_sync) begin
                                r_state  <= ST_WAIT_LOCK;
                                r_stable <= '0;
                            end else if (r_state == ST_WAIT_LOCK) begin
                                r_state  <= ST_STABLE;
                                r_stable <= '0;
                            end else if (r_stable == c_stb_last) begin
                                r_state   <= ST_RUN;
                                clk_ready <= 1'b1;
                                retry_cnt <= '0;
                            end else begin
                                r_stable <= r_stable + c_stb_w'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!r_lock_sync) begin
                            r_state   <= ST_RESET;
                            clk_ready <= 1'b0;
                            lol_pulse <= 1'b1;
                            mmcm_rst  <= 1'b1;
                            r_rst_cnt <= '0;
                        end
                    end
                    ST_FAULT: begin
                        fault <= 1'b1;
                    end
                    default: begin
                        r_state     <= ST_OFF;
                        mmcm_rst    <= 1'b1;
                        mmcm_pwrdwn <= 1'b1;
                        clk_ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MMCM_SEQ_LOL_COUNT_EN
    // Saturating event counter; only the block reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lol_count <= 8'd0;
        end else if (lol_pulse && (lol_count != 8'hFF)) begin
            lol_count <= lol_count + 8'd1;
        end
    end
`else
    assign lol_count = 8'd0;
`endif

endmodule

`default_nettype wire
